// File: rtl/div_16bit_seq.sv
// div_16bit_seq: iterative signed divider (restoring on magnitudes) with sign fix-up,
// quotient saturation and divide-by-zero flagging; fixed WIDTH+2 cycle latency.
module div_16bit_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             OvrFlow,
  output logic             DivZero
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] rem_q, dvd_q;
  logic [WIDTH:0]   dq_q, dvs_q;
  logic             qneg_q, rneg_q;
  logic             busy_q, done_q, ovf_q, dz_q;
  logic [WIDTH-1:0] quot_q, remo_q;
  logic [WIDTH:0]   rem_sh, diff, dvd_ext, dvs_ext;
  logic             borrow, div_zero, sat;
  logic [WIDTH-1:0] quot_d, remo_d;
  assign rem_sh   = {rem_q, dq_q[WIDTH]};
  assign {borrow, diff} = {1'b0, rem_sh} - {1'b0, dvs_q};
  assign dvd_ext  = {dividend[WIDTH-1], dividend};
  assign dvs_ext  = {divisor[WIDTH-1], divisor};
  assign div_zero = (dvs_q == '0);
  // Only a positive quotient can exceed the range (-MIN / -1).
  assign sat      = ~qneg_q & (dq_q > {1'b0, MAX_POS});
  assign quot_d   = div_zero ? (rneg_q ? MIN_NEG : MAX_POS)
                  : sat      ? MAX_POS
                  : WIDTH'(qneg_q ? -dq_q : dq_q);
  assign remo_d   = div_zero ? dvd_q
                  : sat      ? '0
                  : (rneg_q ? -rem_q : rem_q);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dq_q    <= '0;
      dvs_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
      quot_q  <= '0;
      remo_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            dvd_q   <= dividend;
            dq_q    <= dividend[WIDTH-1] ? -dvd_ext : dvd_ext;
            dvs_q   <= divisor[WIDTH-1] ? -dvs_ext : dvs_ext;
            qneg_q  <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            rneg_q  <= dividend[WIDTH-1];
            rem_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= CALC;
          end
        end
        CALC: begin
          rem_q   <= WIDTH'(borrow ? rem_sh : diff);
          dq_q    <= {dq_q[WIDTH-1:0], ~borrow};
          cnt_q   <= cnt_q + 1'b1;
          state_q <= (cnt_q == CW'(WIDTH)) ? FIX : CALC;
        end
        FIX: begin
          quot_q  <= quot_d;
          remo_q  <= remo_d;
          ovf_q   <= div_zero | sat;
          dz_q    <= div_zero;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quot_q;
  assign remainder = remo_q;
  assign OvrFlow   = ovf_q;
  assign DivZero   = dz_q;
endmodule

// File: tb/tb_div_16bit_seq.sv
// tb_div_16bit_seq: directed and randomized checks of the sequential divider against an integer model.
module tb_div_16bit_seq;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [15:0] dividend = '0, divisor = '0;
  logic        busy, done, OvrFlow, DivZero;
  logic [15:0] quotient, remainder;
  int          errs = 0, checks = 0;

  div_16bit_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .OvrFlow(OvrFlow), .DivZero(DivZero)
  );

  always #5 clk = ~clk;

  function automatic logic [33:0] model(input logic [15:0] a, input logic [15:0] b);
    int sa, sb, q, r;
    sa = $signed(a);
    sb = $signed(b);
    if (sb == 0) return {(sa >= 0) ? 16'h7FFF : 16'h8000, a, 2'b11};
    q = sa / sb;
    r = sa % sb;
    if (q > 32767) return {16'h7FFF, 16'h0000, 2'b10};
    return {q[15:0], r[15:0], 2'b00};
  endfunction

  task automatic launch(input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output int bcnt);
    cyc  = 0;
    bcnt = busy ? 1 : 0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (busy) bcnt++;
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({busy, done, quotient, remainder, OvrFlow, DivZero} !== 36'h0) begin
      errs++;
      $display("FAIL reset: got busy=%b done=%b q=%h r=%h ovf=%b dz=%b required all zero",
               busy, done, quotient, remainder, OvrFlow, DivZero);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [15:0] ta[8] = '{16'd100, 16'hFF9C, 16'd100, 16'h8000, 16'h8000, 16'd5, 16'hFFFB, 16'd0};
    logic [15:0] tb[8] = '{16'd7, 16'd7, 16'hFFF9, 16'hFFFF, 16'h0001, 16'd0, 16'd0, 16'd1234};
    logic [33:0] te[8] = '{{16'd14, 16'd2, 2'b00}, {16'hFFF2, 16'hFFFE, 2'b00},
                           {16'hFFF2, 16'h0002, 2'b00}, {16'h7FFF, 16'h0000, 2'b10},
                           {16'h8000, 16'h0000, 2'b00}, {16'h7FFF, 16'h0005, 2'b11},
                           {16'h8000, 16'hFFFB, 2'b11}, {16'h0000, 16'h0000, 2'b00}};
    int cyc, bcnt;
    for (int i = 0; i < 8; i++) begin
      launch(ta[i], tb[i]);
      wait_done(cyc, bcnt);
      checks++;
      if (cyc != 18 || bcnt != 18) begin
        errs++;
        $display("FAIL directed_latency[%0d]: done after %0d, busy %0d cycles, required 18/18", i, cyc, bcnt);
      end
      checks++;
      if ({quotient, remainder, OvrFlow, DivZero} !== te[i]) begin
        errs++;
        $display("FAIL directed[%0d] %h/%h: got q=%h r=%h ovf=%b dz=%b required q=%h r=%h ovf=%b dz=%b",
                 i, ta[i], tb[i], quotient, remainder, OvrFlow, DivZero,
                 te[i][33:18], te[i][17:2], te[i][1], te[i][0]);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errs++;
        $display("FAIL directed_done_pulse[%0d]: done=%b busy=%b one cycle later, required 0/0", i, done, busy);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] a, b;
    logic [33:0] exp;
    int cyc, bcnt;
    for (int i = 0; i < 150; i++) begin
      a = ($urandom_range(0, 9) == 0) ? 16'h8000 : 16'($urandom);
      case ($urandom_range(0, 7))
        0:       b = 16'h0000;
        1:       b = 16'hFFFF;
        2:       b = 16'($urandom_range(1, 15));
        default: b = 16'($urandom);
      endcase
      exp = model(a, b);
      launch(a, b);
      wait_done(cyc, bcnt);
      checks++;
      if (cyc != 18 || {quotient, remainder, OvrFlow, DivZero} !== exp) begin
        errs++;
        $display("FAIL random[%0d] %h/%h: got cyc=%0d q=%h r=%h ovf=%b dz=%b required cyc=18 q=%h r=%h ovf=%b dz=%b",
                 i, a, b, cyc, quotient, remainder, OvrFlow, DivZero,
                 exp[33:18], exp[17:2], exp[1], exp[0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int cyc, bcnt;
    launch(16'd1000, 16'd10);
    repeat (4) @(negedge clk);
    dividend = 16'd7;
    divisor  = 16'd7;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    wait_done(cyc, bcnt);
    checks++;
    if (cyc != 13 || {quotient, remainder, OvrFlow, DivZero} !== {16'd100, 16'd0, 2'b00}) begin
      errs++;
      $display("FAIL ignore_start: got cyc=%0d q=%h r=%h ovf=%b dz=%b required cyc=13 q=0064 r=0000 ovf=0 dz=0",
               cyc, quotient, remainder, OvrFlow, DivZero);
    end
    dividend = 16'd9;
    divisor  = 16'd2;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      errs++;
      $display("FAIL back_to_back_accept: done=%b busy=%b required 0/1", done, busy);
    end
    wait_done(cyc, bcnt);
    checks++;
    if (cyc != 18 || {quotient, remainder, OvrFlow, DivZero} !== {16'd4, 16'd1, 2'b00}) begin
      errs++;
      $display("FAIL back_to_back: got cyc=%0d q=%h r=%h ovf=%b dz=%b required cyc=18 q=0004 r=0001 ovf=0 dz=0",
               cyc, quotient, remainder, OvrFlow, DivZero);
    end
  endtask

  task automatic test_async_reset();
    int cyc, bcnt, dcnt;
    launch(16'd1234, 16'd5);
    repeat (8) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, quotient, remainder, OvrFlow, DivZero} !== 36'h0) begin
      errs++;
      $display("FAIL async_reset: got busy=%b done=%b q=%h r=%h ovf=%b dz=%b required all zero",
               busy, done, quotient, remainder, OvrFlow, DivZero);
    end
    @(negedge clk);
    rst_n = 1'b1;
    dcnt  = 0;
    repeat (30) begin
      @(negedge clk);
      if (done || busy) dcnt++;
    end
    checks++;
    if (dcnt != 0) begin
      errs++;
      $display("FAIL reset_discard: %0d cycles with done/busy after reset, required 0", dcnt);
    end
    launch(16'd1234, 16'd5);
    wait_done(cyc, bcnt);
    checks++;
    if (cyc != 18 || {quotient, remainder, OvrFlow, DivZero} !== {16'd246, 16'd4, 2'b00}) begin
      errs++;
      $display("FAIL after_reset: got cyc=%0d q=%h r=%h ovf=%b dz=%b required cyc=18 q=00f6 r=0004 ovf=0 dz=0",
               cyc, quotient, remainder, OvrFlow, DivZero);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/div_16bit_seq.md
Name: div_16bit_seq

Overview:
- Iterative signed 16-bit divider with saturation: the inverse operation of the saturating add/sub datapath.
- Sits beside the ALU as a multi-cycle unit; the ALU/control stalls on busy and consumes the result on done.
- Uses one shared (WIDTH+1)-bit subtract per cycle (restoring division on magnitudes), then sign-corrects and saturates.
- Flags mirror the adder's OvrFlow convention.

Parameters:
- WIDTH, 16, operand/result width in bits. Iteration count is fixed at WIDTH+1.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- dividend  input  WIDTH  signed two's-complement; captured on the start edge
- divisor  input  WIDTH  signed two's-complement; captured on the start edge
- busy  output  1  high while an operation is in flight
- done  output  1  one-cycle pulse; results valid from this cycle on
- quotient  output  WIDTH  signed, saturated
- remainder  output  WIDTH  signed
- OvrFlow  output  1  quotient saturated
- DivZero  output  1  divisor was zero

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy, done, OvrFlow, DivZero = 0; quotient = remainder = 0. Applies immediately, including mid-operation; the in-flight op is discarded.
- Edge numbering: E0 is the rising edge that samples start=1 in IDLE; Ek is the k-th edge after it.
- FSM states:
  - IDLE: on start=1, capture operands, record result sign (sign(dividend) XOR sign(divisor)) and remainder sign (sign(dividend)), form 17-bit magnitudes; go to CALC with count=0.
  - CALC: edges E1..E17, one restoring step per edge:
    - Shift {rem, dq} left by 1.
    - trial = rem - |divisor| (17-bit).
    - If trial is non-negative: rem = trial and shift in quotient bit 1; otherwise shift in 0.
    - After count reaches 16, go to FIX.
  - FIX: E18. Apply signs, saturate, register quotient/remainder/flags, set done=1, go to IDLE.
- busy is 1 from after E0 through E18 (18 cycles) and 0 after E18.
- done is 1 for exactly the cycle between E18 and E19.
- Outputs hold their values until the next FIX or reset. A new start does not clear them.
- start while busy is ignored: no queuing and no effect. start is sampled in IDLE only, so back-to-back is allowed: start high on the cycle done is high is accepted at E19.
- Rounding: truncation toward zero. Remainder carries the dividend's sign; |remainder| < |divisor|.
- Saturation and overflow:
  - Signed quotient magnitude > 32767 with positive sign gives quotient=16'h7FFF and OvrFlow=1. The only such case is 16'h8000 / 16'hFFFF, which also gives remainder=0.
  - Negative results down to -32768 are exact: 16'h8000 / 16'h0001 gives 16'h8000 with OvrFlow=0.
- Divide by zero:
  - Same fixed latency; DivZero=1 and OvrFlow=1.
  - quotient = 16'h7FFF if dividend >= 0, else 16'h8000.
  - remainder = dividend.
- Flags are recomputed at every FIX; both are 0 for normal results.
- Zero dividend: quotient=0, remainder=0, no flags (divisor nonzero).

Test Plan:
- 100 / 7 (start at E0) -> busy high 18 cycles; done pulse after E18; quotient=16'd14, remainder=16'd2, OvrFlow=0, DivZero=0.
- -100 (16'hFF9C) / 7 -> quotient=16'hFFF2 (-14), remainder=16'hFFFE (-2); 100 / -7 -> quotient=16'hFFF2, remainder=16'h0002.
- 16'h8000 / 16'hFFFF -> quotient=16'h7FFF, remainder=0, OvrFlow=1; then 16'h8000 / 16'h0001 -> quotient=16'h8000, OvrFlow=0.
- 5 / 0 -> quotient=16'h7FFF, remainder=5, DivZero=1, OvrFlow=1; -5 / 0 -> quotient=16'h8000, remainder=16'hFFFB.
- Start 1000/10; pulse start with 7/7 at E5 -> ignored; result quotient=100, remainder=0. Assert start during the done cycle with 9/2 -> accepted at E19; done after a further 18 edges; quotient=4, remainder=1.
- Start 1234/5; drop rst_n at E9 (async, mid-cycle) -> busy/done/outputs immediately 0. After release, no done pulse appears; a new 1234/5 gives quotient=246, remainder=4.
